seq_shift_unit: RTL and testbench

//   Multi-cycle shift engine that consumes the packed shift command word used by the

---
 rtl/seq_shift_unit.sv | 91 +++++++++
 tb/tb_seq_shift_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
// Sequential shift engine: one bit per clock, valid/ready on command and result.
// Consumes the packed {fill, amount, dir} command word.
module seq_shift_unit #(
    parameter int WIDTH = 4,
    parameter bit OP    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] shift,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] overflow,
    output logic             res_valid,
    input  logic             res_ready
);

    localparam int AW = WIDTH - 2;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] data, ovf;
    logic [CW-1:0]    count;
    logic             dir, fill;
    logic [AW-1:0]    amt_field;
    logic [CW-1:0]    amt;
    logic             f;
    logic             accept;

    assign amt_field = shift[WIDTH-2:1];
    assign accept    = cmd_valid && (state == IDLE);

    always_comb begin
        amt = CW'(amt_field);
        if (int'(amt_field) > WIDTH) amt = CW'(WIDTH);
    end

    // Arithmetic mode replicates the sign going right and zero-fills going left.
    always_comb begin
        f = fill;
        if (OP) f = dir ? 1'b0 : data[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (cmd_valid) state_n = (amt == '0) ? DONE : SHIFT;
            SHIFT:   if (count == CW'(1)) state_n = DONE;
            DONE:    if (res_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            ovf   <= '0;
            count <= '0;
            dir   <= 1'b0;
            fill  <= 1'b0;
        end else if (accept) begin
            data  <= in;
            ovf   <= '0;
            count <= amt;
            dir   <= shift[0];
            fill  <= shift[WIDTH-1];
        end else if (state == SHIFT) begin
            count <= count - CW'(1);
            if (!dir) {data, ovf} <= {f, data, ovf[WIDTH-1:1]};
            else      {ovf, data} <= {ovf[WIDTH-2:0], data, f};
        end
    end

    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign out       = data;
    assign overflow  = ovf;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: logical and arithmetic instances
// driven with directed and random commands against a 2W-bit shift model.
module tb_seq_shift_unit;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] o;
        logic [W-1:0] v;
        int           acc;
        int           lat;
    } exp_t;

    logic         clk = 0;
    logic         rst = 1;
    logic [W-1:0] din[2], sh[2], dout[2], dovf[2];
    logic         cv[2], cr[2], rv[2], rr[2];
    bit           rr_auto[2], rr_man[2];
    int           cyc = 0;
    int           total = 0, bad = 0;
    exp_t         q0[$], q1[$];

    seq_shift_unit #(.WIDTH(W), .OP(1'b0)) u_log (
        .clk(clk), .rst(rst), .in(din[0]), .shift(sh[0]),
        .cmd_valid(cv[0]), .cmd_ready(cr[0]), .out(dout[0]),
        .overflow(dovf[0]), .res_valid(rv[0]), .res_ready(rr[0])
    );

    seq_shift_unit #(.WIDTH(W), .OP(1'b1)) u_ari (
        .clk(clk), .rst(rst), .in(din[1]), .shift(sh[1]),
        .cmd_valid(cv[1]), .cmd_ready(cr[1]), .out(dout[1]),
        .overflow(dovf[1]), .res_valid(rv[1]), .res_ready(rr[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    // Shift the operand through a double-width {hi,lo} word in one go.
    function automatic exp_t model(input int op, input logic [W-1:0] d, input logic [W-1:0] s);
        exp_t e;
        logic [2*W-1:0] c;
        int amt;
        amt = int'(s[W-2:1]);
        if (amt > W) amt = W;
        if (!s[0]) begin
            c = {d, {W{1'b0}}};
            if (op == 1) c = $signed(c) >>> amt;
            else begin
                c = c >> amt;
                if (s[W-1]) c = c | ~({(2*W){1'b1}} >> amt);
            end
            e.o = c[2*W-1:W];
            e.v = c[W-1:0];
        end else begin
            c = {{W{1'b0}}, d} << amt;
            if (op == 0 && s[W-1]) c = c | ((2*W)'(1) << amt) - (2*W)'(1);
            e.v = c[2*W-1:W];
            e.o = c[W-1:0];
        end
        e.lat = amt + 1;
        e.acc = 0;
        return e;
    endfunction

    task automatic push(input int idx, input exp_t e);
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic send(input int idx, input logic [W-1:0] d, input logic [W-1:0] s,
                        input bit use_model, input logic [W-1:0] eo, input logic [W-1:0] ev);
        exp_t e;
        bit ok = 0;
        e = model(idx, d, s);
        if (!use_model) begin
            e.o = eo;
            e.v = ev;
        end
        @(posedge clk); #1;
        din[idx] = d;
        sh[idx]  = s;
        cv[idx]  = 1;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (cr[idx]) begin
                e.acc = cyc;
                push(idx, e);
                ok = 1;
            end
            @(posedge clk); #1;
        end
        cv[idx] = 0;
        chk($sformatf("accept%0d", idx), 32'(ok), 1);
    endtask

    task automatic monitor(input int idx);
        exp_t e;
        bit have = 0;
        logic [W-1:0] ho, hv;
        forever begin
            @(negedge clk);
            if (rst) begin
                have = 0;
            end else if (rv[idx]) begin
                chk($sformatf("busy_ready%0d", idx), 32'(cr[idx]), 0);
                if (!have) begin
                    if ((idx == 0 ? q0.size() : q1.size()) == 0) begin
                        chk($sformatf("unexpected%0d", idx), 1, 0);
                    end else begin
                        e = (idx == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("out%0d", idx), 32'(dout[idx]), 32'(e.o));
                        chk($sformatf("ovf%0d", idx), 32'(dovf[idx]), 32'(e.v));
                        chk($sformatf("lat%0d", idx), 32'(cyc - e.acc), 32'(e.lat));
                    end
                    ho = dout[idx];
                    hv = dovf[idx];
                    have = 1;
                end else begin
                    chk($sformatf("hold_out%0d", idx), 32'(dout[idx]), 32'(ho));
                    chk($sformatf("hold_ovf%0d", idx), 32'(dovf[idx]), 32'(hv));
                end
                if (rr[idx]) have = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++)
                rr[i] = rr_auto[i] ? ($urandom_range(0, 3) != 0) : rr_man[i];
        end
    end

    task automatic chk_reset(input int idx);
        chk($sformatf("rst_out%0d", idx), 32'(dout[idx]), 0);
        chk($sformatf("rst_ovf%0d", idx), 32'(dovf[idx]), 0);
        chk($sformatf("rst_rv%0d", idx), 32'(rv[idx]), 0);
        chk($sformatf("rst_cr%0d", idx), 32'(cr[idx]), 1);
    endtask

    initial begin
        bit got;
        for (int i = 0; i < 2; i++) begin
            din[i] = '0; sh[i] = '0; cv[i] = 0; rr[i] = 0;
            rr_auto[i] = 1; rr_man[i] = 0;
        end
        fork
            monitor(0);
            monitor(1);
        join_none
        repeat (2) @(posedge clk);
        #2;
        chk_reset(0);
        chk_reset(1);
        @(negedge clk);
        rst = 0;

        send(0, 4'b1011, 4'b0100, 0, 4'b0010, 4'b1100);
        send(0, 4'b1011, 4'b1011, 0, 4'b0111, 4'b0001);
        send(1, 4'b1000, 4'b1110, 0, 4'b1111, 4'b0000);
        send(0, 4'b0110, 4'b0001, 0, 4'b0110, 4'b0000);

        // Backpressure: result held while a second command waits.
        repeat (10) @(posedge clk);
        @(negedge clk);
        rr_man[0] = 0;
        rr_auto[0] = 0;
        send(0, 4'b1011, 4'b0100, 0, 4'b0010, 4'b1100);
        fork
            send(0, 4'b0110, 4'b0001, 0, 4'b0110, 4'b0000);
            begin
                got = 0;
                for (int k = 0; k < 20 && !got; k++) begin
                    @(negedge clk);
                    got = rv[0];
                end
                chk("bp_valid", 32'(got), 1);
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_rv", 32'(rv[0]), 1);
                    chk("bp_cr", 32'(cr[0]), 0);
                end
                rr_man[0] = 1;
                @(negedge clk);
                rr_man[0] = 0;
                rr_auto[0] = 1;
            end
        join

        // Reset in the middle of an arithmetic shift.
        repeat (10) @(posedge clk);
        send(1, 4'b1000, 4'b1110, 0, 4'b1111, 4'b0000);
        #1;
        rst = 1;
        #1;
        chk_reset(1);
        q1.delete();
        @(posedge clk); #1;
        rst = 0;
        send(1, 4'b1000, 4'b1110, 0, 4'b1111, 4'b0000);

        fork
            repeat (40) send(0, W'($urandom), W'($urandom), 1, '0, '0);
            repeat (40) send(1, W'($urandom), W'($urandom), 1, '0, '0);
        join

        for (int k = 0; k < 200 && (q0.size() + q1.size()) != 0; k++)
            @(posedge clk);
        chk("drain", 32'(q0.size() + q1.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
